// File: rtl/seq_decoder.sv
// seq_decoder: registered N-to-2^N one-hot decoder with enable, direct-load
// and scan modes. The scan mode walks the active line at one step every
// SCAN_DIV clocks and pulses wrap when the index rolls over to line 0.
//
// Build option: define SEQ_DECODER_ACTIVE_LOW_EN for active-low y
// (selected line 0, idle/reset/disabled state all ones). idx and wrap are
// polarity-independent.
module seq_decoder #(
  parameter int unsigned N        = 2,
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  load,
  input  logic [N-1:0]          sel,
  output logic [(1 << N)-1:0]   y,
  output logic [N-1:0]          idx,
  output logic                  wrap
);

  localparam int unsigned LINES = 1 << N;
  localparam int unsigned PW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [N-1:0]  IDX_LAST = N'(LINES - 1);

`ifdef SEQ_DECODER_ACTIVE_LOW_EN
  localparam logic [LINES-1:0] Y_IDLE = '1;
`else
  localparam logic [LINES-1:0] Y_IDLE = '0;
`endif

  logic [PW-1:0]    pre;
  logic [PW-1:0]    pre_next;
  logic [N-1:0]     idx_next;
  logic             wrap_next;
  logic [LINES-1:0] y_next;

  // Next index/prescaler: load beats a scan step; direct mode parks the
  // prescaler; scan freezes while disabled.
  always_comb begin
    idx_next  = idx;
    pre_next  = pre;
    wrap_next = 1'b0;
    if (load) begin
      idx_next = sel;
      pre_next = '0;
    end else if (!mode) begin
      pre_next = '0;
    end else if (en) begin
      if (pre == PRE_LAST) begin
        pre_next  = '0;
        idx_next  = idx + N'(1);
        wrap_next = (idx == IDX_LAST);
      end else begin
        pre_next = pre + PW'(1);
      end
    end
  end

  // Decode the index being written so y tracks idx with one edge of latency;
  // XOR with the idle level flips polarity for the active-low build.
  always_comb begin
    y_next = Y_IDLE;
    if (en) begin
      y_next = (LINES'(1) << idx_next) ^ Y_IDLE;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx  <= '0;
      pre  <= '0;
      wrap <= 1'b0;
      y    <= Y_IDLE;
    end else begin
      idx  <= idx_next;
      pre  <= pre_next;
      wrap <= wrap_next;
      y    <= y_next;
    end
  end

endmodule

// File: doc/seq_decoder.md
Name: seq_decoder

Overview:
Parametrised registered N-to-2^N one-hot decoder with enable. It generalises the team's combinational 2-to-4 decoder. It adds two modes:
- Direct mode: a loaded select value is decoded.
- Scan mode: the active output walks through all 2^N lines at a programmable rate.

It drives digit/row select lines on lab display and keypad boards, and chip selects in bus demos.

Parameters:
N, 2, select width; outputs = 2^N lines (N >= 1)
SCAN_DIV, 4, clock cycles per scan step (>= 1); prescaler width = clog2(SCAN_DIV), minimum 1

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
en  input  1  enable; low forces all outputs inactive and freezes scanning
mode  input  1  0 = direct, 1 = scan
load  input  1  single-cycle strobe; captures sel into index register
sel  input  N  select value captured on load
y  output  2^N  registered one-hot decoded output
idx  output  N  current index register value
wrap  output  1  one-cycle pulse when scan index rolls from 2^N-1 to 0

Behaviour:
- Reset (async on rst rise; held while rst=1) sets:
  - idx = 0
  - prescaler = 0
  - wrap = 0
  - y = all inactive (all 0; see optional feature)
- All state updates on rising clk edge when rst=0.
- Output decode: y <= en ? onehot(idx_next) : 0.
  - 1-cycle latency: a load sampled at edge k shows the new y after edge k.
  - y never has more than one active bit.
- load (either mode): idx <= sel; prescaler <= 0.
  - load has priority over a scan step in the same cycle.
  - load is honoured even when en=0; idx updates, y stays inactive.
- Direct mode (mode=0):
  - idx changes only on load.
  - Prescaler held at 0.
  - wrap = 0.
- Scan mode (mode=1, en=1, load=0):
  - If prescaler == SCAN_DIV-1: prescaler <= 0 and idx <= idx+1, modulo 2^N.
  - Otherwise: prescaler <= prescaler+1.
  - On the step where idx goes 2^N-1 -> 0, wrap is high for exactly that one cycle, aligned with y showing line 0.
  - SCAN_DIV=1: idx steps every cycle; each line is active for 1 cycle.
- en=0 in scan mode:
  - Prescaler and idx freeze; y = 0; wrap = 0.
  - On en returning high, the scan resumes from the frozen prescaler/idx. No step is lost or duplicated.
- Mode change 1 -> 0: prescaler cleared at the next edge; idx retained.
- Mode change 0 -> 1: scanning starts from the current idx with prescaler = 0. The first step occurs SCAN_DIV cycles later.
- rst asserted mid-scan: outputs go inactive immediately, without waiting for clk. After rst releases, scanning starts at idx 0 with a full SCAN_DIV period.
- wrap is registered. It is never asserted in direct mode or on a load that happens to write 0.

Optional Feature:
Macro: SEQ_DECODER_ACTIVE_LOW_EN
- Defined:
  - y is active-low: the selected line is 0 and all other lines are 1.
  - Inactive/reset/en=0 state is all ones.
  - idx and wrap are unaffected.
- Not defined: active-high as described above.
- The bench must check both builds.

Test Plan:
- Reset/direct decode:
  - N=2. Assert rst, release; mode=0, en=1, load sel=2 for 1 cycle -> y=0100 one cycle after the load edge, idx=2.
  - Then load sel=3 -> y=1000.
- Enable gating:
  - With idx=3, drop en -> y=0000 at the next edge, idx stays 3.
  - Raise en -> y=1000.
- Scan sequence:
  - SCAN_DIV=4, mode=1, en=1 from idx=0 -> y steps 0001,0010,0100,1000,0001, each held for 4 cycles.
  - wrap=1 for exactly the one cycle where y returns to 0001.
- Scan freeze/resume:
  - Drop en for 5 cycles after 2 cycles into the idx=1 period, then restore -> y=0000 during the gap.
  - Then y=0010 for the remaining 2 cycles before stepping to 0100.
- Load priority:
  - In scan mode, assert load sel=3 on the cycle the prescaler reaches 3 -> idx=3 (no increment).
  - y=1000 held a full 4 cycles, then wrap pulses as y=0001.
- Async reset and active-low build:
  - Assert rst mid-scan between clock edges -> y cleared before the next edge.
  - Rebuild with SEQ_DECODER_ACTIVE_LOW_EN and repeat the direct decode of sel=2 -> y=1011; reset value y=1111.
